// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator unit: command opcodes and clamp limits.
package accum_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  localparam logic [15:0] SMAX = 16'h7FFF;
  localparam logic [15:0] SMIN = 16'h8000;
  localparam logic [15:0] UMAX = 16'hFFFF;

endpackage

// File: rtl/accumulator_unit_16bit_addsub.sv
// 16-bit adder-subtractor with signed and unsigned overflow flags; purely combinational.
module AdderSubtractor16BitOverflow (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sub_i,
  output logic [15:0] result_o,
  output logic        signed_overflow_o,
  output logic        unsigned_overflow_o
);

  logic [15:0] b_eff;
  logic [16:0] sum;

  // Subtraction is a + ~b + 1, so the carry-out means "no borrow" when subtracting.
  assign b_eff               = b_i ^ {16{sub_i}};
  assign sum                 = {1'b0, a_i} + {1'b0, b_eff} + {16'd0, sub_i};
  assign result_o            = sum[15:0];
  assign signed_overflow_o   = (a_i[15] == b_eff[15]) && (sum[15] != a_i[15]);
  assign unsigned_overflow_o = sum[16] ^ sub_i;

endmodule

// File: rtl/accumulator_unit_16bit.sv
// Registered accumulator with in/out valid-ready handshakes, optional saturation,
// sticky overflow flags and a saturating operation counter.
module accumulator_unit_16bit
  import accum_pkg::*;
#(
  parameter bit SATURATE    = 1'b0,
  parameter bit SIGNED_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [15:0] in_data,
  input  logic        clear_sticky,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] acc_out,
  output logic        zero_out,
  output logic        neg_out,
  output logic        ovf_out,
  output logic        sticky_sovf,
  output logic        sticky_uovf,
  output logic [7:0]  op_count
);

  logic [15:0] acc_q, acc_d;
  logic        out_valid_q, out_valid_d;
  logic        ovf_q, ovf_d;
  logic        sovf_q, sovf_d;
  logic        uovf_q, uovf_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [15:0] sum;
  logic        s_ovf, u_ovf, ovf_sel;
  logic [15:0] sat_val;
  logic        accept;
  op_e         op;

  AdderSubtractor16BitOverflow u_addsub (
    .a_i                 (acc_q),
    .b_i                 (in_data),
    .sub_i               (in_op[0]),
    .result_o            (sum),
    .signed_overflow_o   (s_ovf),
    .unsigned_overflow_o (u_ovf)
  );

  assign op       = op_e'(in_op);
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign ovf_sel  = SIGNED_MODE ? s_ovf : u_ovf;
  assign sat_val  = SIGNED_MODE ? (acc_q[15] ? SMIN : SMAX)
                                : (in_op[0] ? 16'h0000 : UMAX);

  always_comb begin
    // NOTE: every next-state signal starts from its held value so no path infers a latch.
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    sovf_d      = sovf_q;
    uovf_d      = uovf_q;
    cnt_d       = cnt_q;

    if (clear_sticky) begin
      sovf_d = 1'b0;
      uovf_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      unique case (op)
        OP_ADD, OP_SUB: begin
          acc_d  = (ovf_sel && SATURATE) ? sat_val : sum;
          ovf_d  = ovf_sel;
          sovf_d = sovf_d | s_ovf;
          uovf_d = uovf_d | u_ovf;
        end
        OP_LOAD: begin
          acc_d = in_data;
          ovf_d = 1'b0;
        end
        OP_CLEAR: begin
          acc_d  = 16'h0000;
          ovf_d  = 1'b0;
          sovf_d = 1'b0;
          uovf_d = 1'b0;
        end
        default: ;
      endcase
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      acc_q       <= 16'h0000;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      sovf_q      <= 1'b0;
      uovf_q      <= 1'b0;
      cnt_q       <= 8'h00;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      sovf_q      <= sovf_d;
      uovf_q      <= uovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign acc_out     = acc_q;
  assign zero_out    = (acc_q == 16'h0000);
  assign neg_out     = acc_q[15];
  assign ovf_out     = ovf_q;
  assign sticky_sovf = sovf_q;
  assign sticky_uovf = uovf_q;
  assign op_count    = cnt_q;

endmodule

// File: tb/tb_accumulator_unit_16bit.sv
// Bench for accumulator_unit_16bit: three parameter variants share one stimulus stream and
// are compared every cycle against an arithmetic model, plus literal directed checks.
module tb_accumulator_unit_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [15:0] in_data = 16'h0000;
  logic        clear_sticky = 1'b0;
  logic        out_ready = 1'b1;

  logic [2:0]  ir_w, ov_w, zero_w, neg_w, ovf_w, ss_w, su_w;
  logic [15:0] acc_w [3];
  logic [7:0]  cnt_w [3];

  int n_vec = 0;
  int n_mis = 0;
  int n_acc = 0;
  bit started = 1'b0;

  // Variant table: u0 signed saturating, u1 signed wrapping, u2 unsigned saturating.
  bit p_sat [3] = '{1'b1, 1'b0, 1'b1};
  bit p_sm  [3] = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  accumulator_unit_16bit #(.SATURATE(1'b1), .SIGNED_MODE(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[0]), .in_op(in_op),
    .in_data(in_data), .clear_sticky(clear_sticky), .out_valid(ov_w[0]), .out_ready(out_ready),
    .acc_out(acc_w[0]), .zero_out(zero_w[0]), .neg_out(neg_w[0]), .ovf_out(ovf_w[0]),
    .sticky_sovf(ss_w[0]), .sticky_uovf(su_w[0]), .op_count(cnt_w[0]));

  accumulator_unit_16bit #(.SATURATE(1'b0), .SIGNED_MODE(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[1]), .in_op(in_op),
    .in_data(in_data), .clear_sticky(clear_sticky), .out_valid(ov_w[1]), .out_ready(out_ready),
    .acc_out(acc_w[1]), .zero_out(zero_w[1]), .neg_out(neg_w[1]), .ovf_out(ovf_w[1]),
    .sticky_sovf(ss_w[1]), .sticky_uovf(su_w[1]), .op_count(cnt_w[1]));

  accumulator_unit_16bit #(.SATURATE(1'b1), .SIGNED_MODE(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[2]), .in_op(in_op),
    .in_data(in_data), .clear_sticky(clear_sticky), .out_valid(ov_w[2]), .out_ready(out_ready),
    .acc_out(acc_w[2]), .zero_out(zero_w[2]), .neg_out(neg_w[2]), .ovf_out(ovf_w[2]),
    .sticky_sovf(ss_w[2]), .sticky_uovf(su_w[2]), .op_count(cnt_w[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_acc [3];
  bit          m_ov  [3];
  bit          m_ovf [3];
  bit          m_ss  [3];
  bit          m_su  [3];
  int          m_cnt [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit acc_now, so, uo, ov;
      int us, ss;
      if (rst) begin
        m_acc[k] = 16'h0000; m_ov[k] = 0; m_ovf[k] = 0;
        m_ss[k] = 0; m_su[k] = 0; m_cnt[k] = 0;
      end else begin
        acc_now = in_valid && (!m_ov[k] || out_ready);
        if (clear_sticky) begin m_ss[k] = 0; m_su[k] = 0; end
        if (acc_now) begin
          if (k == 0) n_acc++;
          m_cnt[k] = (m_cnt[k] + 1 > 255) ? 255 : m_cnt[k] + 1;
          m_ov[k]  = 1;
          case (in_op)
            2'b00, 2'b01: begin
              if (in_op == 2'b00) begin
                us = int'(m_acc[k]) + int'(in_data);
                ss = int'($signed(m_acc[k])) + int'($signed(in_data));
              end else begin
                us = int'(m_acc[k]) - int'(in_data);
                ss = int'($signed(m_acc[k])) - int'($signed(in_data));
              end
              uo = (us < 0) || (us > 65535);
              so = (ss < -32768) || (ss > 32767);
              ov = p_sm[k] ? so : uo;
              if (ov && p_sat[k]) begin
                if (p_sm[k]) m_acc[k] = (ss > 32767) ? 16'h7FFF : 16'h8000;
                else         m_acc[k] = (us > 65535) ? 16'hFFFF : 16'h0000;
              end else begin
                m_acc[k] = us[15:0];
              end
              m_ovf[k] = ov;
              m_ss[k]  = m_ss[k] | so;
              m_su[k]  = m_su[k] | uo;
            end
            2'b10: begin m_acc[k] = in_data; m_ovf[k] = 0; end
            default: begin
              m_acc[k] = 16'h0000; m_ovf[k] = 0; m_ss[k] = 0; m_su[k] = 0;
            end
          endcase
        end else if (out_ready) begin
          m_ov[k] = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("u%0d.in_ready", k),  {31'd0, ir_w[k]}, {31'd0, !rst && (!m_ov[k] || out_ready)});
        check($sformatf("u%0d.out_valid", k), {31'd0, ov_w[k]}, {31'd0, m_ov[k]});
        check($sformatf("u%0d.acc_out", k),   {16'd0, acc_w[k]}, {16'd0, m_acc[k]});
        check($sformatf("u%0d.zero_out", k),  {31'd0, zero_w[k]}, {31'd0, m_acc[k] == 16'h0000});
        check($sformatf("u%0d.neg_out", k),   {31'd0, neg_w[k]}, {31'd0, m_acc[k] >= 16'h8000});
        check($sformatf("u%0d.ovf_out", k),   {31'd0, ovf_w[k]}, {31'd0, m_ovf[k]});
        check($sformatf("u%0d.sticky_sovf", k), {31'd0, ss_w[k]}, {31'd0, m_ss[k]});
        check($sformatf("u%0d.sticky_uovf", k), {31'd0, su_w[k]}, {31'd0, m_su[k]});
        check($sformatf("u%0d.op_count", k),  {24'd0, cnt_w[k]}, m_cnt[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clear_sticky = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] data, input bit cs = 1'b0);
    bit ok = 1'b0;
    in_valid = 1'b1; in_op = op; in_data = data; clear_sticky = cs;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = ir_w[0];
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_mis++;
      $display("FAIL send_timeout: op %0d not accepted within 50 cycles", op);
    end
    in_valid = 1'b0; clear_sticky = 1'b0;
  endtask

  initial begin
    logic [15:0] edges [5];
    int base, cyc;
    edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

    @(posedge clk); #1;
    started = 1'b1;
    check("reset.acc_out", {16'd0, acc_w[0]}, 32'h0);
    check("reset.zero_out", {31'd0, zero_w[0]}, 32'h1);
    check("reset.in_ready_in_rst", {31'd0, ir_w[0]}, 32'h0);
    rst = 1'b0;

    // Basic sequence with a borrow.
    send(2'b10, 16'h0005);
    check("seq.load", {16'd0, acc_w[0]}, 32'h0005);
    send(2'b00, 16'h0003);
    check("seq.add", {16'd0, acc_w[0]}, 32'h0008);
    send(2'b01, 16'h0010);
    check("seq.sub", {16'd0, acc_w[0]}, 32'hFFF8);
    check("seq.neg", {31'd0, neg_w[0]}, 32'h1);
    check("seq.count", {24'd0, cnt_w[0]}, 32'd3);
    check("seq.sovf", {31'd0, ss_w[0]}, 32'h0);
    check("seq.uovf", {31'd0, su_w[0]}, 32'h1);
    check("seq.u2_clamp", {16'd0, acc_w[2]}, 32'h0000);

    // Signed saturation vs wrap.
    do_reset();
    send(2'b10, 16'h7FF0);
    send(2'b00, 16'h0100);
    check("sat.acc", {16'd0, acc_w[0]}, 32'h7FFF);
    check("sat.ovf", {31'd0, ovf_w[0]}, 32'h1);
    check("sat.sovf", {31'd0, ss_w[0]}, 32'h1);
    check("wrap.acc", {16'd0, acc_w[1]}, 32'h80F0);
    send(2'b01, 16'h0001);
    check("sat.sub_acc", {16'd0, acc_w[0]}, 32'h7FFE);
    check("sat.sub_ovf", {31'd0, ovf_w[0]}, 32'h0);
    check("sat.sovf_held", {31'd0, ss_w[0]}, 32'h1);

    do_reset();
    send(2'b10, 16'h8000);
    send(2'b01, 16'h0001);
    check("wrap.sub_acc", {16'd0, acc_w[1]}, 32'h7FFF);
    check("wrap.sub_ovf", {31'd0, ovf_w[1]}, 32'h1);
    check("wrap.sub_sovf", {31'd0, ss_w[1]}, 32'h1);
    check("wrap.sub_zero", {31'd0, zero_w[1]}, 32'h0);
    check("satneg.acc", {16'd0, acc_w[0]}, 32'h8000);

    // Backpressure.
    out_ready = 1'b1;
    send(2'b10, 16'h0010);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b00; in_data = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.in_ready", {31'd0, ir_w[0]}, 32'h0);
      check("bp.acc_stable", {16'd0, acc_w[0]}, 32'h0010);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.in_ready_up", {31'd0, ir_w[0]}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.acc_inc", {16'd0, acc_w[0]}, 32'h0011);

    // clear_sticky against an overflowing add, then CLEAR.
    send(2'b10, 16'h7FFF);
    send(2'b00, 16'h0001, 1'b1);
    check("cs.sovf_wins", {31'd0, ss_w[0]}, 32'h1);
    send(2'b11, 16'h1234);
    check("clr.acc", {16'd0, acc_w[0]}, 32'h0);
    check("clr.zero", {31'd0, zero_w[0]}, 32'h1);
    check("clr.sovf", {31'd0, ss_w[0]}, 32'h0);
    check("clr.uovf", {31'd0, su_w[0]}, 32'h0);

    // Reset mid-stream with a pending result.
    send(2'b10, 16'h1234);
    out_ready = 1'b0;
    check("abort.pending", {31'd0, ov_w[0]}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort.out_valid", {31'd0, ov_w[0]}, 32'h0);
    check("abort.acc", {16'd0, acc_w[0]}, 32'h0);
    check("abort.count", {24'd0, cnt_w[0]}, 32'h0);
    rst = 1'b0; out_ready = 1'b1;

    // Randomized traffic until 300 accepts.
    base = n_acc;
    cyc = 0;
    while (n_acc - base < 300 && cyc < 4000) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      in_op        = 2'($urandom_range(0, 3));
      in_data      = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 4)] : 16'($urandom);
      clear_sticky = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; clear_sticky = 1'b0;
    if (n_acc - base < 300) begin
      n_mis++;
      $display("FAIL random_budget: only %0d accepts", n_acc - base);
    end
    check("count.sat", {24'd0, cnt_w[0]}, 32'd255);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/accumulator_unit_16bit.md
Name: accumulator_unit_16bit

Overview:
- Registered accumulator stage built around the 16-bit adder-subtractor (AdderSubtractor16BitOverflow) already in arithmetics/.
- Accepts a stream of operand/op commands over a valid/ready handshake and applies each to an internal 16-bit accumulator.
- Presents the registered result and flags downstream over a second valid/ready handshake.
- Keeps sticky overflow flags, optional saturation, and an operation counter. It is the state-holding consumer of the adder-subtractor's result and flags.

Parameters:
- SATURATE, 0, 1 = clamp the accumulator on overflow instead of wrapping.
- SIGNED_MODE, 1, 1 = saturation and sticky overflow use signed_overflow; 0 = they use unsigned_overflow.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid && in_ready.
- in_op  input  2  00 ADD, 01 SUB (acc - in_data), 10 LOAD, 11 CLEAR.
- in_data  input  16  operand.
- clear_sticky  input  1  one-cycle pulse; clears the sticky flags.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- acc_out  output  16  accumulator value after the last accepted op.
- zero_out  output  1  acc_out == 0.
- neg_out  output  1  acc_out[15].
- ovf_out  output  1  overflow (mode-selected) on the last op, before saturation.
- sticky_sovf  output  1  OR of signed_overflow over accepted ADD/SUB ops since last clear.
- sticky_uovf  output  1  OR of unsigned_overflow over accepted ADD/SUB ops since last clear.
- op_count  output  8  accepted-op count; saturates at 255.

Behaviour:
- Reset (rst=1 at an edge): acc=0, out_valid=0, acc_out=0, zero_out=1, neg_out=0, ovf_out=0, both sticky flags=0, op_count=0.
  - Reset is also the abort path mid-stream: any pending result is discarded.
  - in_ready is 0 while rst is high.
- in_ready = !out_valid || out_ready. This is a single-entry skid-free output register, so back-to-back accepts sustain 1 op/cycle.
- On accept at edge N, the following are registered and visible at N+1 with out_valid=1 (latency 1 cycle):
  - acc
  - acc_out = acc
  - zero_out and neg_out, derived from the new acc
  - ovf_out
  - op_count
- ADD/SUB:
  - Adder inputs: a=acc, b=in_data, sub=in_op[0].
  - Overflow source: ovf = SIGNED_MODE ? signed_overflow : unsigned_overflow.
  - If ovf and SATURATE=1:
    - SIGNED_MODE=1: acc = 7FFF if a[15]==0, else 8000.
    - SIGNED_MODE=0: acc = FFFF for ADD, 0000 for SUB.
  - Otherwise acc = result (wrap).
  - Both sticky flags update from their respective adder flags regardless of mode.
- LOAD: acc = in_data. ovf_out=0, stickies unchanged.
- CLEAR: acc = 0. ovf_out=0. Both sticky flags cleared.
- out_valid:
  - Set on accept.
  - Cleared when out_ready && !accept.
  - Stays 1 when accept and consume happen in the same cycle.
- Simultaneous events:
  - clear_sticky with an overflowing ADD/SUB accept: the new overflow wins (sticky=1).
  - clear_sticky with a CLEAR op: stickies = 0.
- op_count increments on every accept, including CLEAR, and holds at 255. Only rst zeroes it.
- in_op, in_data and clear_sticky are ignored (except clear_sticky) when no accept occurs.
- No state change while out_valid=1 and out_ready=0.

Decomposition:
- Shared package accum_pkg:
  - op encodings OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR
  - constants SMAX=16'h7FFF, SMIN=16'h8000, UMAX=16'hFFFF
- One sub-module: the existing 16-bit adder-subtractor (AdderSubtractor16BitOverflow), instantiated once, purely combinational on acc/in_data.
- Saturation mux, flag logic, handshake, and counter live in accumulator_unit_16bit.

Test Plan:
- Reset, then LOAD 0x0005, ADD 0x0003, SUB 0x0010 with out_ready=1 -> acc_out 0x0005, 0x0008, 0xFFF8 on consecutive cycles; neg_out=1 on the last; op_count=3; stickies: sovf=0, uovf=1 (borrow).
- SATURATE=1, SIGNED_MODE=1: LOAD 0x7FF0, ADD 0x0100 -> acc_out=0x7FFF, ovf_out=1, sticky_sovf=1; then SUB 0x0001 -> 0x7FFE, ovf_out=0, sticky_sovf remains 1.
- SATURATE=0: LOAD 0x8000, SUB 0x0001 -> acc_out=0x7FFF (wrap), ovf_out=1, sticky_sovf=1, zero_out=0.
- Backpressure: out_ready=0 after one accept -> in_ready=0 and acc_out stable for 5 cycles despite in_valid=1 with ADD 0x0001; raise out_ready -> next op accepted the same cycle and acc increments by exactly 1.
- Same cycle: clear_sticky=1 with an overflowing ADD (0x7FFF+0x0001) -> sticky_sovf=1; next cycle CLEAR op -> acc_out=0, zero_out=1, both stickies=0.
- Assert rst mid-stream with out_valid=1 -> next cycle all outputs at reset values; 300 accepted ops -> op_count=255.
